risk_tile_dma: RTL and testbench

RISK_TILE_DMA -- requirements
Module: risk_tile_dma

---
 rtl/risk_tile_dma.sv | 227 ++++++++++++++++++++++
 tb/tb_risk_tile_dma.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risk_tile_dma.sv
// rtl/risk_tile_dma.sv - tile DMA between bank memory and load/store streams; optional 2D walk under RISK_DMA_2D_EN
module risk_tile_dma #(
    parameter int SZ         = 4,
    parameter int LOGCNT     = 5,
    parameter int BITS       = 18,
    parameter int MEM_LAT    = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = 10 + LOGCNT,
    localparam int DW        = BITS * SZ * SZ
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_step,
    input  logic [7:0]    cmd_count,
    input  logic [AW-2:0] cmd_stride_x,
    input  logic [AW-2:0] cmd_stride_y,
`ifdef RISK_DMA_2D_EN
    input  logic [7:0]    cmd_rows,
    input  logic [AW-1:0] cmd_row_stride,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [AW-2:0] mem_stride_x,
    output logic [AW-2:0] mem_stride_y,
    output logic          mem_we,
    output logic [DW-1:0] mem_dat_w,
    input  logic [DW-1:0] mem_dat_r,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LCW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state;
    logic          wr_q;
    logic [AW-1:0] step_q;
    logic [7:0]    count_q;
    logic [7:0]    col;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] addr_hold;
    logic [AW-2:0] stride_x_q;
    logic [AW-2:0] stride_y_q;
    logic [LCW-1:0] since_issue;
`ifdef RISK_DMA_2D_EN
    logic [7:0]    rows_q;
    logic [7:0]    row;
    logic [AW-1:0] row_stride_q;
    logic [AW-1:0] row_addr;
    logic          row_last;
`endif

    logic [MEM_LAT-1:0] vsr;
    logic [FCW-1:0]     in_flight;
    logic [FCW-1:0]     fifo_count;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [DW-1:0]      fifo_mem [FIFO_DEPTH];

    logic [FCW:0] credit_sum;
    logic         credit_ok;
    logic         load_issue;
    logic         store_issue;
    logic         issue;
    logic         col_last;
    logic         push;
    logic         pop;
    logic         drain_exit;

    // Credits count both reads still in the memory pipe and data already queued, so the FIFO cannot overflow.
    assign credit_sum  = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok   = credit_sum < (FCW + 1)'(FIFO_DEPTH);
    assign load_issue  = (state == S_RUN) && !wr_q && credit_ok && !reset;
    assign store_issue = (state == S_RUN) && wr_q && wr_valid && !reset;
    assign issue       = load_issue || store_issue;
    assign col_last    = (col == count_q - 8'd1);
`ifdef RISK_DMA_2D_EN
    assign row_last    = (row == rows_q - 8'd1);
`endif
    assign push        = vsr[MEM_LAT-1];
    assign pop         = rd_valid && rd_ready;
    assign drain_exit  = (state == S_DRAIN) && (vsr == '0) && (since_issue == LCW'(MEM_LAT));

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign wr_ready     = (state == S_RUN) && wr_q;
    assign mem_we       = store_issue;
    assign mem_dat_w    = wr_data;
    assign mem_addr     = issue ? cur_addr : addr_hold;
    assign mem_stride_x = stride_x_q;
    assign mem_stride_y = stride_y_q;
    assign rd_valid     = (fifo_count != '0);
    assign rd_data      = fifo_mem[rptr];

    // Command FSM: latch command, walk tile addresses with adders, wait out memory latency, pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            wr_q         <= 1'b0;
            step_q       <= '0;
            count_q      <= '0;
            col          <= '0;
            cur_addr     <= '0;
            addr_hold    <= '0;
            stride_x_q   <= '0;
            stride_y_q   <= '0;
            since_issue  <= LCW'(MEM_LAT);
`ifdef RISK_DMA_2D_EN
            rows_q       <= '0;
            row          <= '0;
            row_stride_q <= '0;
            row_addr     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (issue) begin
                addr_hold   <= cur_addr;
                since_issue <= LCW'(1);
            end else if (since_issue != LCW'(MEM_LAT)) begin
                since_issue <= since_issue + LCW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        wr_q       <= cmd_write;
                        step_q     <= cmd_step;
                        count_q    <= cmd_count;
                        stride_x_q <= cmd_stride_x;
                        stride_y_q <= cmd_stride_y;
                        cur_addr   <= cmd_base;
                        col        <= '0;
`ifdef RISK_DMA_2D_EN
                        rows_q       <= cmd_rows;
                        row_stride_q <= cmd_row_stride;
                        row_addr     <= cmd_base;
                        row          <= '0;
                        state <= (cmd_count == 8'd0 || cmd_rows == 8'd0) ? S_DRAIN : S_RUN;
`else
                        state <= (cmd_count == 8'd0) ? S_DRAIN : S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (!col_last) begin
                            col      <= col + 8'd1;
                            cur_addr <= cur_addr + step_q;
                        end else begin
                            col <= '0;
`ifdef RISK_DMA_2D_EN
                            if (row_last) begin
                                state <= S_DRAIN;
                            end else begin
                                row      <= row + 8'd1;
                                row_addr <= row_addr + row_stride_q;
                                cur_addr <= row_addr + row_stride_q;
                            end
`else
                            state <= S_DRAIN;
`endif
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_exit) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-latency token pipe, in-flight counter and FIFO pointers/occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsr        <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            vsr[0] <= load_issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                vsr[i] <= vsr[i-1];
            end
            case ({load_issue, push})
                2'b10:   in_flight <= in_flight + FCW'(1);
                2'b01:   in_flight <= in_flight - FCW'(1);
                default: in_flight <= in_flight;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wptr <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
        end
    end

    // FIFO storage captures returning read data when its latency token exits the pipe.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= mem_dat_r;
        end
    end

endmodule

// File: tb/tb_risk_tile_dma.sv
// tb/tb_risk_tile_dma.sv - scoreboard bench for risk_tile_dma
module tb_risk_tile_dma;

    localparam int SZ = 4, LOGCNT = 5, BITS = 18, MEM_LAT = 4, FIFO_DEPTH = 8;
    localparam int AW = 10 + LOGCNT, DW = BITS * SZ * SZ;

    logic          clk, reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_base, cmd_step;
    logic [7:0]    cmd_count;
    logic [AW-2:0] cmd_stride_x, cmd_stride_y;
`ifdef RISK_DMA_2D_EN
    logic [7:0]    cmd_rows;
    logic [AW-1:0] cmd_row_stride;
`endif
    logic [AW-1:0] mem_addr;
    logic [AW-2:0] mem_stride_x, mem_stride_y;
    logic          mem_we;
    logic [DW-1:0] mem_dat_w, mem_dat_r;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done;

    risk_tile_dma #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_step(cmd_step), .cmd_count(cmd_count),
        .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
`ifdef RISK_DMA_2D_EN
        .cmd_rows(cmd_rows), .cmd_row_stride(cmd_row_stride),
`endif
        .mem_addr(mem_addr), .mem_stride_x(mem_stride_x), .mem_stride_y(mem_stride_y),
        .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int rd_beats = 0, we_pulses = 0, done_pulses = 0, addr_changes = 0;
    int cyc = 0, last_we_cyc = 0, done_cyc = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] rdq [$];
    logic [AW+DW-1:0] wq [$];

    function automatic logic [DW-1:0] tile_of(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        for (int k = 0; k < SZ * SZ; k++) begin
            t[k*BITS +: BITS] = BITS'((32'(a) * (k + 3)) ^ (k * 32'h155));
        end
        return t;
    endfunction

    // Bank memory model: returns the tile of the address presented MEM_LAT cycles earlier.
    logic [AW-1:0] lat_q [0:MEM_LAT];
    initial for (int i = 0; i <= MEM_LAT; i++) lat_q[i] = '0;
    always @(negedge clk) begin
        lat_q[0] <= mem_addr;
        for (int i = 1; i <= MEM_LAT; i++) lat_q[i] <= lat_q[i-1];
    end
    assign mem_dat_r = tile_of(lat_q[MEM_LAT]);

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboards on every load beat and store strobe.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (rd_valid && rd_ready) begin
                rd_beats++;
                if (rdq.size() == 0) check("rd_unexpected_beat", 1, 0);
                else check("rd_data", rd_data, rdq.pop_front());
            end
            if (mem_we) begin
                logic [AW+DW-1:0] e;
                we_pulses++;
                last_we_cyc = cyc;
                check("we_handshake", wr_valid && wr_ready, 1);
                if (wq.size() == 0) check("we_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("we_addr", mem_addr, e[AW+DW-1:DW]);
                    check("we_data", mem_dat_w, e[DW-1:0]);
                end
            end
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
            end
            if (mem_addr !== prev_addr) addr_changes++;
            prev_addr = mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] step, input logic [7:0] cnt);
        cmd_write = wr; cmd_base = base; cmd_step = step; cmd_count = cnt;
        cmd_stride_x = AW'($urandom) >> 1;
        cmd_stride_y = AW'($urandom) >> 1;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int d0 = done_pulses;
        int n = 0;
        while (done_pulses == d0 && n < maxc) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done_pulses != d0, 1);
        repeat (3) tick();
        check({tag, "_done_once"}, done_pulses - d0, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b0, ac0, we0, nv;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_step = '0;
        cmd_count = '0; cmd_stride_x = '0; cmd_stride_y = '0;
`ifdef RISK_DMA_2D_EN
        cmd_rows = 8'd1; cmd_row_stride = '0;
`endif
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_stride_x", mem_stride_x, 0);
        check("rst_stride_y", mem_stride_y, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        reset = 1'b0;
        tick();

        // Three-tile load, consecutive addresses, data via latency model.
        rd_ready = 1'b1;
        b0 = rd_beats;
        rdq.push_back(tile_of(15'h0100));
        rdq.push_back(tile_of(15'h0110));
        rdq.push_back(tile_of(15'h0120));
        send(1'b0, 15'h0100, 15'h0010, 8'd3);
        @(negedge clk); check("a_addr0", mem_addr, 15'h0100);
        check("a_busy", busy, 1);
        check("a_stride_x", mem_stride_x, cmd_stride_x);
        check("a_stride_y", mem_stride_y, cmd_stride_y);
        check("a_mem_we", mem_we, 0);
        @(negedge clk); check("a_addr1", mem_addr, 15'h0110);
        @(negedge clk); check("a_addr2", mem_addr, 15'h0120);
        tick();
        wait_done("a", 50);
        check("a_rdq_empty", rdq.size(), 0);
        check("a_beats", rd_beats - b0, 3);

        // Twenty-tile load with sink stalled: credits cap issues at FIFO_DEPTH.
        rd_ready = 1'b0;
        b0 = rd_beats;
        ac0 = addr_changes;
        for (int j = 0; j < 20; j++) rdq.push_back(tile_of(AW'(15'h0200 + j)));
        send(1'b0, 15'h0200, 15'h0001, 8'd20);
        repeat (30) tick();
        check("b_issue_count", addr_changes - ac0, FIFO_DEPTH);
        check("b_stall_addr", mem_addr, 15'h0207);
        check("b_rd_valid", rd_valid, 1);
        check("b_busy", busy, 1);
        rd_ready = 1'b1;
        wait_done("b", 300);
        check("b_rdq_empty", rdq.size(), 0);
        check("b_beats", rd_beats - b0, 20);

        // Four-tile store with wr_valid toggling; a late valid in DRAIN must not write.
        we0 = we_pulses;
        nv = 0;
        send(1'b1, 15'h0300, 15'h0002, 8'd4);
        for (int b = 0; b < 10; b++) begin
            wr_valid = (b % 2 == 0) && (b <= 8);
            wr_data = {9{$urandom}};
            if (wr_valid && nv < 4) begin
                wq.push_back({AW'(15'h0300 + 2 * nv), wr_data});
                nv++;
            end
            if (b == 8) begin
                check("c_wr_ready_drain", wr_ready, 0);
                check("c_mem_we_drain", mem_we, 0);
            end
            tick();
        end
        wr_valid = 1'b0;
        wait_done("c", 50);
        check("c_we_pulses", we_pulses - we0, 4);
        check("c_wq_empty", wq.size(), 0);
        check("c_done_after_lat", (done_cyc - last_we_cyc) >= MEM_LAT, 1);

        // Address wrap at the top of the AW-bit space.
        rdq.push_back(tile_of(15'h7FF0));
        rdq.push_back(tile_of(15'h0000));
        send(1'b0, 15'h7FF0, 15'h0010, 8'd2);
        @(negedge clk); check("d_addr0", mem_addr, 15'h7FF0);
        @(negedge clk); check("d_addr_wrap", mem_addr, 15'h0000);
        tick();
        wait_done("d", 50);
        check("d_rdq_empty", rdq.size(), 0);

        // Reset in the middle of a ten-tile load aborts and discards in-flight data.
        rd_ready = 1'b0;
        send(1'b0, 15'h0400, 15'h0001, 8'd10);
        repeat (6) tick();
        check("e_pre_rd_valid", rd_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("e_busy", busy, 0);
        check("e_rd_valid", rd_valid, 0);
        check("e_mem_we", mem_we, 0);
        rdq.delete();
        rd_ready = 1'b1;
        b0 = rd_beats;
        rdq.push_back(tile_of(15'h0500));
        tick();
        send(1'b0, 15'h0500, 15'h0004, 8'd1);
        wait_done("e", 50);
        check("e_rdq_empty", rdq.size(), 0);
        check("e_beats", rd_beats - b0, 1);

        // Zero-count command completes without issuing.
        ac0 = addr_changes;
        b0 = rd_beats;
        send(1'b0, 15'h0600, 15'h0001, 8'd0);
        wait_done("f", 20);
        check("f_no_issue", addr_changes - ac0, 0);
        check("f_addr_held", mem_addr, 15'h0500);
        check("f_no_beats", rd_beats - b0, 0);

`ifdef RISK_DMA_2D_EN
        // Two rows of two tiles, row-major.
        rdq.push_back(tile_of(15'h0000));
        rdq.push_back(tile_of(15'h0001));
        rdq.push_back(tile_of(15'h0040));
        rdq.push_back(tile_of(15'h0041));
        cmd_rows = 8'd2; cmd_row_stride = 15'h0040;
        send(1'b0, 15'h0000, 15'h0001, 8'd2);
        @(negedge clk); check("g_addr0", mem_addr, 15'h0000);
        @(negedge clk); check("g_addr1", mem_addr, 15'h0001);
        @(negedge clk); check("g_addr2", mem_addr, 15'h0040);
        @(negedge clk); check("g_addr3", mem_addr, 15'h0041);
        tick();
        wait_done("g", 50);
        check("g_rdq_empty", rdq.size(), 0);
        ac0 = addr_changes;
        cmd_rows = 8'd0;
        send(1'b0, 15'h0100, 15'h0001, 8'd2);
        wait_done("h", 20);
        check("h_no_issue", addr_changes - ac0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
